cis_timing_gen: RTL

//   Generates contact-image-sensor line timing: pixel clock CISCLK and start-integration pulse CISSI.

---
 rtl/cis_timing_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cis_timing_gen.sv
// Contact-image-sensor line timing: CISCLK / CISSI generation, per-pixel strobes
// and line boundary events, with dpi_mode and line_gap latched once per line.
module cis_timing_gen #(
   parameter int CLK_DIV = 4,
   parameter int SI_CLKS = 1,
   parameter int PIX_M0  = 5184,
   parameter int PIX_M1  = 2592,
   parameter int IDX_W   = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scan_en,
   input  logic             dpi_mode,
   input  logic [15:0]      line_gap,
   output logic             CISCLK,
   output logic             CISSI,
   output logic             dpi_mode_q,
   output logic             pix_valid,
   output logic [IDX_W-1:0] pix_idx,
   output logic             line_start,
   output logic             line_done,
   output logic [15:0]      line_cnt,
   output logic             busy
);

   localparam int                DIV_W     = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV);
   localparam logic [15:0]       SI_LAST   = 16'(SI_CLKS - 1);
   localparam logic [15:0]       PIX0_LAST = 16'(PIX_M0 - 1);
   localparam logic [15:0]       PIX1_LAST = 16'(PIX_M1 - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SI,
      ST_PIX,
      ST_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [15:0]        per_q, per_d;
   logic [15:0]        line_gap_q, line_gap_d;
   logic               dpi_mode_d;
   logic               cisclk_q, cisclk_d;
   logic               cissi_q, cissi_d;
   logic               pix_valid_q, pix_valid_d;
   logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
   logic               line_start_q, line_start_d;
   logic               line_done_q, line_done_d;
   logic [15:0]        line_cnt_q, line_cnt_d;
   logic               busy_q, busy_d;
   logic               start_line;
   logic               last_per;

   function automatic logic [15:0] pix_last(input logic mode);
      return mode ? PIX1_LAST : PIX0_LAST;
   endfunction

   // Sequencer: line_done_q marks the final clk of a line, so the end-of-line
   // decision (restart or go idle) is taken directly from it.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      per_d      = per_q;
      dpi_mode_d = dpi_mode_q;
      line_gap_d = line_gap_q;
      start_line = 1'b0;
      if (state_q == ST_IDLE) begin
         div_d      = '0;
         per_d      = '0;
         start_line = scan_en;
      end else if (line_done_q) begin
         if (scan_en) begin
            start_line = 1'b1;
         end else begin
            state_d = ST_IDLE;
            div_d   = '0;
            per_d   = '0;
         end
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         per_d = per_q + 16'd1;
         case (state_q)
            ST_SI: begin
               if (per_q == SI_LAST) begin
                  state_d = ST_PIX;
                  per_d   = '0;
               end
            end
            ST_PIX: begin
               if (per_q == pix_last(dpi_mode_q)) begin
                  state_d = ST_GAP;
                  per_d   = '0;
               end
            end
            default: begin
            end
         endcase
      end else begin
         div_d = DIV_W'(div_q + 1'b1);
      end
      if (start_line) begin
         state_d    = ST_SI;
         div_d      = '0;
         per_d      = '0;
         dpi_mode_d = dpi_mode;
         line_gap_d = line_gap;
      end
   end

   // Outputs are registered, so they are derived from the next-cycle position.
   always_comb begin
      last_per     = ((state_d == ST_PIX) && (per_d == pix_last(dpi_mode_d)) && (line_gap_d == 16'd0)) ||
                     ((state_d == ST_GAP) && (per_d == line_gap_d - 16'd1));
      line_done_d  = last_per && (div_d == DIV_LAST);
      line_cnt_d   = line_cnt_q + {15'd0, line_done_d};
      line_start_d = start_line;
      busy_d       = (state_d != ST_IDLE);
      cisclk_d     = (state_d != ST_IDLE) && (div_d >= DIV_HALF);
      cissi_d      = (div_d == '0) ? (state_d == ST_SI) : cissi_q;
      pix_valid_d  = (state_d == ST_PIX) && (div_d == DIV_HALF);
      pix_idx_d    = (state_d == ST_PIX) ? per_d[IDX_W-1:0] : pix_idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         per_q        <= '0;
         line_gap_q   <= '0;
         dpi_mode_q   <= 1'b0;
         cisclk_q     <= 1'b0;
         cissi_q      <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_idx_q    <= '0;
         line_start_q <= 1'b0;
         line_done_q  <= 1'b0;
         line_cnt_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         per_q        <= per_d;
         line_gap_q   <= line_gap_d;
         dpi_mode_q   <= dpi_mode_d;
         cisclk_q     <= cisclk_d;
         cissi_q      <= cissi_d;
         pix_valid_q  <= pix_valid_d;
         pix_idx_q    <= pix_idx_d;
         line_start_q <= line_start_d;
         line_done_q  <= line_done_d;
         line_cnt_q   <= line_cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign CISCLK     = cisclk_q;
   assign CISSI      = cissi_q;
   assign pix_valid  = pix_valid_q;
   assign pix_idx    = pix_idx_q;
   assign line_start = line_start_q;
   assign line_done  = line_done_q;
   assign line_cnt   = line_cnt_q;
   assign busy       = busy_q;

endmodule
